// File: rtl/cube_gen_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : cube_gen_scheduler
// Purpose  : Generation scheduler between the Conway simulator and the cube
//            scanner: rate prescaler, run/step control, tick/done handshake and
//            display latch. Define CUBE_SCHED_FRAME_SYNC_EN to add the shadow
//            buffer that is swapped to the display on FrameSync.
// Revision : 1.0 - initial release
// ============================================================================
module cube_gen_scheduler #(
  parameter  int CUBE_DIM    = 8,
  parameter  int BASE_PERIOD = 4000000,
  parameter  int RATE_LEVELS = 8,
  parameter  int DEF_LEVEL   = 0,
  localparam int NCELLS      = CUBE_DIM ** 3,
  localparam int RATE_W      = (RATE_LEVELS > 1) ? $clog2(RATE_LEVELS) : 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Run,
  input  logic              Step,
  input  logic              RateUp,
  input  logic              RateDn,
  input  logic [NCELLS-1:0] SimCells,
  input  logic              SimDone,
  output logic              SimTick,
  input  logic              FrameSync,
  output logic [NCELLS-1:0] DispCells,
  output logic [RATE_W-1:0] Rate,
  output logic              Busy,
  output logic              Overrun
);

  localparam int              c_CNT_W    = (BASE_PERIOD > 1) ? $clog2(BASE_PERIOD + 1) : 1;
  localparam logic [RATE_W-1:0] c_MAX_RATE = RATE_W'(RATE_LEVELS - 1);

  localparam logic [1:0] c_IDLE       = 2'd0;
  localparam logic [1:0] c_WAIT_DONE  = 2'd1;
`ifdef CUBE_SCHED_FRAME_SYNC_EN
  localparam logic [1:0] c_WAIT_FRAME = 2'd2;
`endif

  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic [c_CNT_W-1:0] r_cnt;
  logic [RATE_W-1:0] r_rate;
  logic [RATE_W-1:0] w_rate_next;
  logic              w_rate_chg;
  logic [31:0]       w_period_raw;
  logic [31:0]       w_period;
  logic              w_tick_due;
  logic              w_request;
  logic              w_fire;
  logic              w_load;
  logic              w_swap;
  logic              r_simtick;
  logic              r_busy;
  logic              r_overrun;
  logic [NCELLS-1:0] r_disp;

  // Period halves per level but never drops below one clock.
  assign w_period_raw = 32'(BASE_PERIOD) >> r_rate;
  assign w_period     = (w_period_raw == 32'd0) ? 32'd1 : w_period_raw;
  assign w_tick_due   = Run && (32'(r_cnt) == (w_period - 32'd1));
  assign w_request    = w_tick_due || (!Run && Step);

  always_comb begin
    w_rate_next = r_rate;
    if (RateUp && !RateDn && (r_rate != c_MAX_RATE))
      w_rate_next = r_rate + 1'b1;
    else if (RateDn && !RateUp && (r_rate != '0))
      w_rate_next = r_rate - 1'b1;
  end
  assign w_rate_chg = (w_rate_next != r_rate);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_cnt  <= '0;
      r_rate <= RATE_W'(DEF_LEVEL);
    end else begin
      r_rate <= w_rate_next;
      if (w_rate_chg || w_tick_due)
        r_cnt <= '0;
      else if (Run)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= c_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE:      if (w_request) w_state_next = c_WAIT_DONE;
`ifdef CUBE_SCHED_FRAME_SYNC_EN
      c_WAIT_DONE:  if (SimDone)   w_state_next = c_WAIT_FRAME;
      c_WAIT_FRAME: if (FrameSync) w_state_next = c_IDLE;
`else
      c_WAIT_DONE:  if (SimDone)   w_state_next = c_IDLE;
`endif
      default:     w_state_next = c_IDLE;
    endcase
  end

  always_comb begin
    w_fire = 1'b0;
    w_load = 1'b0;
    w_swap = 1'b0;
    case (r_state)
      c_IDLE:       w_fire = w_request;
      c_WAIT_DONE:  w_load = SimDone;
`ifdef CUBE_SCHED_FRAME_SYNC_EN
      c_WAIT_FRAME: w_swap = FrameSync;
`endif
      default:      ;
    endcase
  end

  // A tick that lands while a generation is in flight is dropped and flagged.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_simtick <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_simtick <= w_fire;
      r_busy    <= (w_state_next != c_IDLE);
      if (w_tick_due && (r_state != c_IDLE))
        r_overrun <= 1'b1;
      else if (w_rate_chg)
        r_overrun <= 1'b0;
    end
  end

`ifdef CUBE_SCHED_FRAME_SYNC_EN
  logic [NCELLS-1:0] r_shadow;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_shadow <= '0;
      r_disp   <= '0;
    end else begin
      if (w_load) r_shadow <= SimCells;
      if (w_swap) r_disp   <= r_shadow;
    end
  end
`else
  logic w_frame_sync_unused;
  assign w_frame_sync_unused = FrameSync ^ w_swap;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)      r_disp <= '0;
    else if (w_load) r_disp <= SimCells;
  end
`endif

  assign SimTick   = r_simtick;
  assign DispCells = r_disp;
  assign Rate      = r_rate;
  assign Busy      = r_busy;
  assign Overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_cube_gen_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_cube_gen_scheduler
// Purpose  : Directed scenarios plus randomized run against a behavioural model
//            of cube_gen_scheduler (CUBE_DIM=2, BASE_PERIOD=16, 4 rate levels).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cube_gen_scheduler;

  localparam int c_BASE = 16;
  localparam int c_LVLS = 4;

  logic       Clk, Reset, Run, Step, RateUp, RateDn, SimDone, FrameSync;
  logic [7:0] SimCells;
  logic       SimTick, Busy, Overrun;
  logic [7:0] DispCells;
  logic [1:0] Rate;

  int total, bad, cyc;
  int resp_cnt, resp_delay;
  bit auto_resp, fs_pending;

  cube_gen_scheduler #(
    .CUBE_DIM(2), .BASE_PERIOD(c_BASE), .RATE_LEVELS(c_LVLS), .DEF_LEVEL(0)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Step(Step), .RateUp(RateUp),
    .RateDn(RateDn), .SimCells(SimCells), .SimDone(SimDone), .SimTick(SimTick),
    .FrameSync(FrameSync), .DispCells(DispCells), .Rate(Rate), .Busy(Busy),
    .Overrun(Overrun)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Behavioural reference: generation phases tracked as flags, period from level.
  int         m_rate, m_cnt, m_per, m_nr;
  bit         m_due, m_tick, m_busy, m_wf, m_ovr;
  logic [7:0] m_disp, m_shadow;

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      m_rate = 0; m_cnt = 0; m_tick = 0; m_busy = 0; m_wf = 0; m_ovr = 0;
      m_disp = 8'h00; m_shadow = 8'h00;
    end else begin
      m_per = c_BASE >> m_rate;
      if (m_per < 1) m_per = 1;
      m_due = Run && (m_cnt == m_per - 1);
      m_nr  = m_rate;
      if (RateUp && !RateDn)      m_nr = (m_rate < c_LVLS - 1) ? m_rate + 1 : c_LVLS - 1;
      else if (RateDn && !RateUp) m_nr = (m_rate > 0) ? m_rate - 1 : 0;
      if (m_nr != m_rate || m_due) m_cnt = 0;
      else if (Run)                m_cnt = m_cnt + 1;
      if (m_due && m_busy)     m_ovr = 1;
      else if (m_nr != m_rate) m_ovr = 0;
      m_tick = 0;
      if (!m_busy) begin
        if (m_due || (!Run && Step)) begin m_tick = 1; m_busy = 1; end
      end else if (!m_wf) begin
        if (SimDone) begin
`ifdef CUBE_SCHED_FRAME_SYNC_EN
          m_shadow = SimCells; m_wf = 1;
`else
          m_disp = SimCells; m_busy = 0;
`endif
        end
      end else if (FrameSync) begin
        m_disp = m_shadow; m_wf = 0; m_busy = 0;
      end
      m_rate = m_nr;
    end
  end

  // One clock: outputs settle after the edge, pulses drop at the falling edge,
  // and the optional auto-responder answers ticks with SimDone then FrameSync.
  task automatic cycle();
    @(posedge Clk);
    cyc++;
    #1;
    if (auto_resp && SimTick) resp_cnt = resp_delay;
    @(negedge Clk);
    Step = 0; RateUp = 0; RateDn = 0; SimDone = 0; FrameSync = 0;
    if (fs_pending) begin FrameSync = 1; fs_pending = 0; end
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin SimDone = 1; fs_pending = 1; end
    end
  endtask

  task automatic test_reset();
    Reset = 0; Run = 0; Step = 0; RateUp = 0; RateDn = 0; SimDone = 0;
    FrameSync = 0; SimCells = 8'h00;
    repeat (3) cycle();
    total++; if (SimTick !== 1'b0)     begin bad++; $display("FAIL reset_simtick got=%0h exp=0", SimTick); end
    total++; if (DispCells !== 8'h00)  begin bad++; $display("FAIL reset_disp got=%0h exp=0", DispCells); end
    total++; if (Rate !== 2'd0)        begin bad++; $display("FAIL reset_rate got=%0d exp=0", Rate); end
    total++; if (Busy !== 1'b0)        begin bad++; $display("FAIL reset_busy got=%0h exp=0", Busy); end
    total++; if (Overrun !== 1'b0)     begin bad++; $display("FAIL reset_overrun got=%0h exp=0", Overrun); end
    Reset = 1;
    cycle();
  endtask

  task automatic test_free_run();
    int t_prev, n;
    t_prev = -1; n = 0;
    Run = 1; auto_resp = 1; resp_delay = 3;
    for (int i = 0; i < 80; i++) begin
      cycle();
      if (SimTick) begin
        if (t_prev >= 0) begin
          total++;
          if (cyc - t_prev != 16) begin bad++; $display("FAIL free_run_period got=%0d exp=16", cyc - t_prev); end
        end
        t_prev = cyc; n++;
      end
    end
    total++; if (n < 4)           begin bad++; $display("FAIL free_run_ticks got=%0d exp>=4", n); end
    total++; if (Overrun !== 1'b0) begin bad++; $display("FAIL free_run_overrun got=%0h exp=0", Overrun); end
  endtask

  task automatic test_rate();
    int w, t0;
    resp_delay = 1;
    RateUp = 1; cycle();
    RateUp = 1; cycle();
    total++; if (Rate !== 2'd2) begin bad++; $display("FAIL rate_up2 got=%0d exp=2", Rate); end
    w = 0;
    do begin cycle(); w++; end while (!SimTick && w < 20);
    total++; if (!SimTick) begin bad++; $display("FAIL rate_first_tick got=timeout exp=tick"); end
    for (int k = 0; k < 2; k++) begin
      t0 = cyc; w = 0;
      do begin cycle(); w++; end while (!SimTick && w < 20);
      total++;
      if (!SimTick || (cyc - t0 != 4)) begin bad++; $display("FAIL rate2_period got=%0d exp=4", cyc - t0); end
    end
    repeat (3) begin RateUp = 1; cycle(); end
    total++; if (Rate !== 2'd3) begin bad++; $display("FAIL rate_saturate got=%0d exp=3", Rate); end
    RateUp = 1; RateDn = 1; cycle();
    total++; if (Rate !== 2'd3) begin bad++; $display("FAIL rate_both got=%0d exp=3", Rate); end
  endtask

  task automatic test_step();
    Run = 0;
    repeat (8) cycle();
    auto_resp = 0; resp_cnt = 0; fs_pending = 0;
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL step_idle got=%0h exp=0", Busy); end
    Step = 1; cycle();
    total++; if (SimTick !== 1'b1) begin bad++; $display("FAIL step_tick got=%0h exp=1", SimTick); end
    total++; if (Busy !== 1'b1)    begin bad++; $display("FAIL step_busy got=%0h exp=1", Busy); end
    Step = 1; cycle();
    for (int i = 0; i < 3; i++) begin
      total++; if (SimTick !== 1'b0) begin bad++; $display("FAIL step_ignored got=%0h exp=0", SimTick); end
      cycle();
    end
    SimCells = 8'hA5; SimDone = 1; cycle();
`ifdef CUBE_SCHED_FRAME_SYNC_EN
    for (int i = 0; i < 3; i++) begin
      total++; if (DispCells !== 8'h00) begin bad++; $display("FAIL step_hold got=%0h exp=0", DispCells); end
      total++; if (Busy !== 1'b1)       begin bad++; $display("FAIL step_wait_busy got=%0h exp=1", Busy); end
      cycle();
    end
    FrameSync = 1; cycle();
`endif
    total++; if (DispCells !== 8'hA5) begin bad++; $display("FAIL step_disp got=%0h exp=a5", DispCells); end
    total++; if (Busy !== 1'b0)       begin bad++; $display("FAIL step_done got=%0h exp=0", Busy); end
  endtask

  task automatic test_overrun();
    int w, n;
    RateDn = 1; cycle();
    RateUp = 1; cycle();
    total++; if (Overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear_pre got=%0h exp=0", Overrun); end
    Run = 1; w = 0;
    do begin cycle(); w++; end while (!SimTick && w < 10);
    total++; if (!SimTick) begin bad++; $display("FAIL ovr_first_tick got=timeout exp=tick"); end
    n = 0;
    repeat (10) begin cycle(); if (SimTick) n++; end
    total++; if (n != 0)           begin bad++; $display("FAIL ovr_extra_tick got=%0d exp=0", n); end
    total++; if (Overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%0h exp=1", Overrun); end
    Run = 0; SimDone = 1; cycle();
    FrameSync = 1; cycle();
    total++; if (Overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%0h exp=1", Overrun); end
    RateDn = 1; cycle();
    total++; if (Rate !== 2'd2)    begin bad++; $display("FAIL ovr_rate got=%0d exp=2", Rate); end
    total++; if (Overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%0h exp=0", Overrun); end
  endtask

  task automatic test_same_cycle();
    Reset = 0; cycle(); Reset = 1; cycle();
    Step = 1; cycle();
    SimCells = 8'h3C; SimDone = 1; FrameSync = 1; cycle();
`ifdef CUBE_SCHED_FRAME_SYNC_EN
    total++; if (DispCells !== 8'h00) begin bad++; $display("FAIL same_cycle_nobypass got=%0h exp=0", DispCells); end
    total++; if (Busy !== 1'b1)       begin bad++; $display("FAIL same_cycle_busy got=%0h exp=1", Busy); end
    FrameSync = 1; cycle();
`endif
    total++; if (DispCells !== 8'h3C) begin bad++; $display("FAIL swap_disp got=%0h exp=3c", DispCells); end
    total++; if (Busy !== 1'b0)       begin bad++; $display("FAIL swap_idle got=%0h exp=0", Busy); end
  endtask

  task automatic test_async_reset();
    RateUp = 1; cycle();
    Step = 1; cycle();
    SimCells = 8'h5A; SimDone = 1; cycle();
    #2 Reset = 0;
    #1;
    total++; if (SimTick !== 1'b0)    begin bad++; $display("FAIL areset_simtick got=%0h exp=0", SimTick); end
    total++; if (DispCells !== 8'h00) begin bad++; $display("FAIL areset_disp got=%0h exp=0", DispCells); end
    total++; if (Rate !== 2'd0)       begin bad++; $display("FAIL areset_rate got=%0d exp=0", Rate); end
    total++; if (Busy !== 1'b0)       begin bad++; $display("FAIL areset_busy got=%0h exp=0", Busy); end
    total++; if (Overrun !== 1'b0)    begin bad++; $display("FAIL areset_overrun got=%0h exp=0", Overrun); end
    @(negedge Clk);
    Reset = 1;
    cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(31) == 0) Run = ~Run;
      Step      = ($urandom_range(7) == 0);
      RateUp    = ($urandom_range(19) == 0);
      RateDn    = ($urandom_range(19) == 0);
      SimDone   = ($urandom_range(3) == 0);
      FrameSync = ($urandom_range(3) == 0);
      SimCells  = 8'($urandom);
      cycle();
      total++; if (SimTick !== m_tick)      begin bad++; $display("FAIL rnd_simtick cyc=%0d got=%0h exp=%0h", cyc, SimTick, m_tick); end
      total++; if (DispCells !== m_disp)    begin bad++; $display("FAIL rnd_disp cyc=%0d got=%0h exp=%0h", cyc, DispCells, m_disp); end
      total++; if (Rate !== 2'(m_rate))     begin bad++; $display("FAIL rnd_rate cyc=%0d got=%0d exp=%0d", cyc, Rate, m_rate); end
      total++; if (Busy !== m_busy)         begin bad++; $display("FAIL rnd_busy cyc=%0d got=%0h exp=%0h", cyc, Busy, m_busy); end
      total++; if (Overrun !== m_ovr)       begin bad++; $display("FAIL rnd_overrun cyc=%0d got=%0h exp=%0h", cyc, Overrun, m_ovr); end
    end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    resp_cnt = 0; resp_delay = 3; auto_resp = 0; fs_pending = 0;
    test_reset();
    test_free_run();
    test_rate();
    test_step();
    test_overrun();
    test_same_cycle();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
